// File: rtl/dmem_responder_pkg.sv
// Shared definitions for the data-memory responder: FSM states, default geometry, lane merge.
package dmem_responder_pkg;

  localparam int          DMEM_WORD_W      = 32;
  localparam logic [31:0] DMEM_DEF_BASE    = 32'h0000_0000;
  localparam int          DMEM_DEF_DEPTH   = 4096;
  localparam int          DMEM_DEF_LATENCY = 2;

  typedef enum logic [1:0] {
    DMEM_IDLE = 2'd0,
    DMEM_WAIT = 2'd1,
    DMEM_DONE = 2'd2
  } dmem_state_e;

  // Replace the byte lanes selected by be with the matching lanes of wdata.
  function automatic logic [DMEM_WORD_W-1:0] dmem_merge(
    input logic [DMEM_WORD_W-1:0] old_word,
    input logic [DMEM_WORD_W-1:0] wdata,
    input logic [3:0]             be
  );
    logic [DMEM_WORD_W-1:0] merged;
    merged = old_word;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) merged[i*8 +: 8] = wdata[i*8 +: 8];
    end
    return merged;
  endfunction

endpackage

// File: rtl/dmem_responder_array.sv
// DEPTH x 32 word RAM: one synchronous port, byte-lane writes, registered read-before-write output.
module dmem_responder_array
  import dmem_responder_pkg::*;
#(
  parameter int DEPTH = DMEM_DEF_DEPTH,
  parameter int IDX_W = $clog2(DEPTH)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   en,
  input  logic                   clear,
  input  logic                   we,
  input  logic [3:0]             be,
  input  logic [IDX_W-1:0]       idx,
  input  logic [DMEM_WORD_W-1:0] wdata,
  output logic [DMEM_WORD_W-1:0] rdata
);

  logic [DMEM_WORD_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (en && we) mem[idx] <= dmem_merge(mem[idx], wdata, be);
  end

  // Output register sees the pre-write word; clear zeroes it for rejected accesses.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rdata <= '0;
    end else if (en) begin
      rdata <= mem[idx];
    end else if (clear) begin
      rdata <= '0;
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory slave for the CPU D port: fixed-latency load/store with a one-cycle DReady pulse.
// Optional write trace compiled in when DMEM_TRACE_EN is defined.
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = DMEM_DEF_BASE,
  parameter int          DEPTH     = DMEM_DEF_DEPTH,
  parameter int          LATENCY   = DMEM_DEF_LATENCY
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] DPC,
  input  logic [31:0] DAddr,
  input  logic        DREn,
  input  logic        DWEn,
  input  logic [3:0]  DByteEn,
  input  logic [31:0] DWData,
  output logic [31:0] DRData,
  output logic        DReady,
  output logic        DErr
);

  localparam int          IDX_W = $clog2(DEPTH);
  localparam int          CNT_W = $clog2(LATENCY + 1);
  localparam logic [32:0] SPAN  = 33'(DEPTH) << 2;

  dmem_state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             accept, access;

  logic [31:0] addr_q;
  logic [3:0]  be_q;
  logic [31:0] wdata_q;
  logic        wen_q;
  logic [31:0] off;
  logic        in_range;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    accept  = 1'b0;
    access  = 1'b0;
    unique case (state_q)
      DMEM_IDLE: begin
        if (DREn || DWEn) begin
          accept  = 1'b1;
          cnt_d   = CNT_W'(LATENCY);
          state_d = DMEM_WAIT;
        end
      end
      DMEM_WAIT: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          access  = 1'b1;
          state_d = DMEM_DONE;
        end
      end
      DMEM_DONE: state_d = DMEM_IDLE;
      default:   state_d = DMEM_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= DMEM_IDLE;
      cnt_q   <= '0;
      DReady  <= 1'b0;
      DErr    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      DReady  <= (state_d == DMEM_DONE);
      if (access) DErr <= !in_range;
    end
  end

  // The request is captured once at acceptance; the requester's later values are never used.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      addr_q  <= '0;
      be_q    <= '0;
      wdata_q <= '0;
      wen_q   <= 1'b0;
    end else if (accept) begin
      addr_q  <= DAddr;
      be_q    <= DByteEn;
      wdata_q <= DWData;
      wen_q   <= DWEn;
    end
  end

  assign off      = addr_q - BASE_ADDR;
  assign in_range = (addr_q >= BASE_ADDR) && ({1'b0, off} < SPAN);

  dmem_responder_array #(
    .DEPTH (DEPTH),
    .IDX_W (IDX_W)
  ) u_array (
    .clk   (clk),
    .reset (reset),
    .en    (access && in_range),
    .clear (access && !in_range),
    .we    (wen_q),
    .be    (be_q),
    .idx   (off[IDX_W+1:2]),
    .wdata (wdata_q),
    .rdata (DRData)
  );

`ifdef DMEM_TRACE_EN
  logic [31:0] pc_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)      pc_q <= '0;
    else if (accept) pc_q <= DPC;
  end

  // DRData holds the pre-write word during DONE, so the merge reproduces what was stored.
  always_ff @(posedge clk) begin
    if (reset && state_q == DMEM_DONE && !DErr && wen_q && be_q != 4'h0)
      $display("@%h: *%h <= %h", pc_q, {addr_q[31:2], 2'b00},
               dmem_merge(DRData, wdata_q, be_q));
  end
`else
  logic unused_pc;
  assign unused_pc = ^DPC;
`endif

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder (LATENCY=2 main instance, LATENCY=1 side instance).
module tb_dmem_responder;

  logic        clk;
  logic        reset;
  logic [31:0] DPC, DAddr, DWData;
  logic        DREn, DWEn;
  logic [3:0]  DByteEn;
  logic [31:0] DRData;
  logic        DReady, DErr;

  logic [31:0] d1_addr, d1_wdata, d1_rdata;
  logic        d1_ren, d1_wen, d1_ready, d1_err;
  logic [3:0]  d1_be;

  int compared   = 0;
  int mismatched = 0;
  int cyc        = 0;

  typedef struct {
    logic [31:0] data;
    logic        chk;
    logic        err;
    string       name;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  dmem_responder #(.BASE_ADDR(32'h0), .DEPTH(4096), .LATENCY(2)) dut (
    .clk(clk), .reset(reset), .DPC(DPC), .DAddr(DAddr), .DREn(DREn), .DWEn(DWEn),
    .DByteEn(DByteEn), .DWData(DWData), .DRData(DRData), .DReady(DReady), .DErr(DErr)
  );

  dmem_responder #(.BASE_ADDR(32'h0), .DEPTH(4096), .LATENCY(1)) dut1 (
    .clk(clk), .reset(reset), .DPC(32'h0), .DAddr(d1_addr), .DREn(d1_ren), .DWEn(d1_wen),
    .DByteEn(d1_be), .DWData(d1_wdata), .DRData(d1_rdata), .DReady(d1_ready), .DErr(d1_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Monitor: every DReady pulse consumes one scoreboard entry.
  always @(negedge clk) begin
    if (reset && DReady) begin
      if (sb.size() == 0) begin
        checkOutput("spurious_dready", 32'd1, 32'd0);
      end else begin
        mon_e = sb.pop_front();
        checkOutput({mon_e.name, "_err"}, {31'd0, DErr}, {31'd0, mon_e.err});
        if (mon_e.chk) checkOutput({mon_e.name, "_data"}, DRData, mon_e.data);
      end
    end
  end

  task automatic applyStimulus(input string name, input logic [31:0] addr, input logic ren,
                               input logic wen, input logic [3:0] be, input logic [31:0] wd,
                               input logic chk, input logic [31:0] exp_d, input logic exp_e);
    exp_t e;
    int   t;
    bit   seen;
    @(negedge clk);
    DAddr = addr; DREn = ren; DWEn = wen; DByteEn = be; DWData = wd; DPC = 32'h100 + addr;
    e.data = exp_d; e.chk = chk; e.err = exp_e; e.name = name;
    sb.push_back(e);
    @(negedge clk);
    t    = cyc;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (DReady) seen = 1'b1;
    end
    if (!seen && sb.size() > 0) void'(sb.pop_front());
    checkOutput({name, "_latency"}, seen ? 32'(cyc - t) : 32'hFFFF_FFFF, 32'd2);
    DREn = 1'b0; DWEn = 1'b0;
    @(negedge clk);
    checkOutput({name, "_pulse"}, {31'd0, DReady}, 32'd0);
  endtask

  task automatic applyStimulusLat1(input string name, input logic [31:0] addr, input logic ren,
                                   input logic wen, input logic [3:0] be, input logic [31:0] wd,
                                   input logic chk, input logic [31:0] exp_d);
    int t;
    bit seen;
    @(negedge clk);
    d1_addr = addr; d1_ren = ren; d1_wen = wen; d1_be = be; d1_wdata = wd;
    @(negedge clk);
    t    = cyc;
    seen = d1_ready;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (d1_ready) seen = 1'b1;
    end
    checkOutput({name, "_latency"}, seen ? 32'(cyc - t) : 32'hFFFF_FFFF, 32'd1);
    if (chk) checkOutput({name, "_data"}, d1_rdata, exp_d);
    d1_ren = 1'b0; d1_wen = 1'b0;
    @(negedge clk);
    checkOutput({name, "_pulse"}, {31'd0, d1_ready}, 32'd0);
  endtask

  task automatic applyReset();
    reset = 1'b0;
    DREn = 1'b0; DWEn = 1'b0; d1_ren = 1'b0; d1_wen = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    int hits;
    reset = 1'b1;
    DPC = '0; DAddr = '0; DREn = 1'b0; DWEn = 1'b0; DByteEn = '0; DWData = '0;
    d1_addr = '0; d1_ren = 1'b0; d1_wen = 1'b0; d1_be = '0; d1_wdata = '0;

    applyReset();
    checkOutput("reset_dready", {31'd0, DReady}, 32'd0);
    checkOutput("reset_derr",   {31'd0, DErr},   32'd0);
    checkOutput("reset_drdata", DRData,          32'd0);
    hits = 0;
    repeat (20) begin
      @(negedge clk);
      if (DReady) hits++;
    end
    checkOutput("idle_no_dready", 32'(hits), 32'd0);

    applyStimulus("wr_full",   32'h10, 1'b0, 1'b1, 4'hF, 32'hDEADBEEF, 1'b0, 32'h0, 1'b0);
    applyStimulus("rd_full",   32'h10, 1'b1, 1'b0, 4'hF, 32'h0,        1'b1, 32'hDEADBEEF, 1'b0);
    applyStimulus("wr_lane1",  32'h10, 1'b0, 1'b1, 4'b0010, 32'h0000AA00, 1'b0, 32'h0, 1'b0);
    applyStimulus("rd_lane1",  32'h13, 1'b1, 1'b0, 4'h0, 32'h0,        1'b1, 32'hDEADAAEF, 1'b0);
    applyStimulus("wr_be0",    32'h10, 1'b0, 1'b1, 4'h0, 32'hFFFFFFFF, 1'b0, 32'h0, 1'b0);
    applyStimulus("rd_be0",    32'h10, 1'b1, 1'b0, 4'hF, 32'h0,        1'b1, 32'hDEADAAEF, 1'b0);

    applyStimulus("wr_oor",    32'h4000, 1'b0, 1'b1, 4'hF, 32'hFFFFFFFF, 1'b1, 32'h0, 1'b1);
    applyStimulus("rd_oor",    32'h4000, 1'b1, 1'b0, 4'hF, 32'h0,        1'b1, 32'h0, 1'b1);
    applyStimulus("rd_word0",  32'h0,    1'b1, 1'b0, 4'hF, 32'h0,        1'b1, 32'h0, 1'b0);
    applyStimulus("rd_last",   32'h3FFC, 1'b1, 1'b0, 4'hF, 32'h0,        1'b1, 32'h0, 1'b0);

    // Abandon a write mid-flight with reset.
    @(negedge clk);
    DAddr = 32'h20; DWEn = 1'b1; DREn = 1'b0; DByteEn = 4'hF; DWData = 32'h12345678;
    @(negedge clk);
    reset = 1'b0;
    DWEn  = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    hits  = 0;
    repeat (6) begin
      @(negedge clk);
      if (DReady) hits++;
    end
    checkOutput("abandon_no_dready", 32'(hits), 32'd0);
    applyStimulus("rd_abandon", 32'h20, 1'b1, 1'b0, 4'hF, 32'h0, 1'b1, 32'h0, 1'b0);

    applyStimulus("rw_same",   32'h10, 1'b1, 1'b1, 4'hF, 32'h00000001, 1'b1, 32'hDEADAAEF, 1'b0);
    applyStimulus("rd_after_rw", 32'h10, 1'b1, 1'b0, 4'hF, 32'h0,      1'b1, 32'h00000001, 1'b0);

    applyStimulusLat1("l1_wr", 32'h8, 1'b0, 1'b1, 4'hF, 32'hCAFEF00D, 1'b0, 32'h0);
    applyStimulusLat1("l1_rd", 32'h8, 1'b1, 1'b0, 4'hF, 32'h0,        1'b1, 32'hCAFEF00D);

    repeat (3) @(negedge clk);
    checkOutput("scoreboard_drained", 32'(sb.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
